// File: rtl/param_boot_ram.sv
// Parametrised single-port data RAM for the RSSB CPU with boot-time zero fill,
// a streaming program-load port, selectable read latency and address range checking.
module param_boot_ram #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 256,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter int LOAD_BASE      = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              ready,
    output logic              addr_err,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic              load_last,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_done,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    localparam state_e            RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic [ADDR_W-1:0] PTR_LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_BASE    = ADDR_W'(LOAD_BASE);
    localparam logic [ADDR_W:0]   DEPTH_EXT   = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              addr_err_q, addr_err_d;
    logic              load_done_q, load_done_d;

    logic              in_range;
    logic [DATA_W-1:0] rd_word;
    logic              cpu_rd;
    logic              cpu_err;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign ready     = (state_q == ST_RUN);
    assign dbg_state = state_q;

    // Read-before-write falls out naturally: rd_word sees the array before the edge commits.
    always_comb begin
        in_range = ({1'b0, addr} < DEPTH_EXT);
        rd_word  = in_range ? mem[addr] : '0;
        cpu_rd   = ready & re;
        cpu_err  = ready & (re | we) & ~in_range;
    end

    // Single write port shared by the clear sweep, the load stream and CPU writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
            end
            ST_LOAD: begin
                mem_we    = load_valid;
                mem_wdata = load_data;
            end
            ST_RUN: begin
                mem_we    = we & in_range;
                mem_waddr = addr;
                mem_wdata = wdata;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        load_done_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = PTR_BASE;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
                    if (load_last) begin
                        state_d     = ST_RUN;
                        load_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RESET_STATE;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        rdata_d    = cpu_rd ? rd_word : rdata_q;
        rvalid_d   = cpu_rd;
        addr_err_d = cpu_err;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            ptr_q       <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            addr_err_q  <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            addr_err_q  <= addr_err_d;
            load_done_q <= load_done_d;
        end
    end

    // Latency 0 bypasses the read registers; rdata_q still holds the last value between reads.
    generate
        if (READ_LATENCY == 0) begin : g_comb_read
            assign rdata    = cpu_rd ? rd_word : rdata_q;
            assign rvalid   = cpu_rd;
            assign addr_err = cpu_err;
        end else begin : g_reg_read
            assign rdata    = rdata_q;
            assign rvalid   = rvalid_q;
            assign addr_err = addr_err_q;
        end
    endgenerate

    assign load_done = load_done_q;

endmodule

// File: tb/tb_param_boot_ram.sv
// Bench for param_boot_ram: three configurations share one stimulus stream and are
// each compared every cycle against a behavioural model, plus directed vectors.
module tb_param_boot_ram;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic       re, we, load_start, load_valid, load_last;
    logic [7:0] addr, wdata, load_data;

    logic [2:0][7:0] rdata_w;
    logic [2:0]      rvalid_w, ready_w, err_w, done_w;
    logic [2:0][1:0] state_w;

    // dut 0: defaults with LOAD_BASE=0xFE; dut 1: DEPTH=200; dut 2: latency 0, no clear
    param_boot_ram #(.DEPTH(256), .READ_LATENCY(1), .CLEAR_ON_RESET(1), .LOAD_BASE(254)) u_a (
        .clock(clock), .reset(reset), .re(re), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_w[0]), .rvalid(rvalid_w[0]), .ready(ready_w[0]), .addr_err(err_w[0]),
        .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
        .load_data(load_data), .load_done(done_w[0]), .dbg_state(state_w[0]));
    param_boot_ram #(.DEPTH(200), .READ_LATENCY(1), .CLEAR_ON_RESET(1), .LOAD_BASE(0)) u_b (
        .clock(clock), .reset(reset), .re(re), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_w[1]), .rvalid(rvalid_w[1]), .ready(ready_w[1]), .addr_err(err_w[1]),
        .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
        .load_data(load_data), .load_done(done_w[1]), .dbg_state(state_w[1]));
    param_boot_ram #(.DEPTH(256), .READ_LATENCY(0), .CLEAR_ON_RESET(0), .LOAD_BASE(0)) u_c (
        .clock(clock), .reset(reset), .re(re), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_w[2]), .rvalid(rvalid_w[2]), .ready(ready_w[2]), .addr_err(err_w[2]),
        .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
        .load_data(load_data), .load_done(done_w[2]), .dbg_state(state_w[2]));

    int cfg_depth [3] = '{256, 200, 256};
    int cfg_lat   [3] = '{1, 1, 0};
    int cfg_clr   [3] = '{1, 1, 0};
    int cfg_base  [3] = '{254, 0, 0};

    // Behavioural model: contents plus a "known" flag for words never written.
    logic [7:0] m_mem   [3][256];
    bit         m_known [3][256];
    int         m_clear_left [3];
    bit         m_loading [3];
    int         m_load_cnt [3];
    logic [7:0] m_rd_q [3];
    bit         m_rd_known [3];
    bit         m_rv_q [3], m_err_q [3], m_done_q [3];

    logic [7:0] obs_rdata [3];
    logic       obs_rvalid [3], obs_ready [3], obs_err [3], obs_done [3];

    int total = 0;
    int bad   = 0;

    function automatic bit m_ready(int i);
        return (m_clear_left[i] == 0) && !m_loading[i];
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_clear_left[i] = (cfg_clr[i] != 0) ? cfg_depth[i] : 0;
            m_loading[i]    = 1'b0;
            m_load_cnt[i]   = 0;
            m_rd_q[i]       = 8'h00;
            m_rd_known[i]   = 1'b1;
            m_rv_q[i]       = 1'b0;
            m_err_q[i]      = 1'b0;
            m_done_q[i]     = 1'b0;
        end
    endtask

    task automatic model_step();
        if (reset) return;
        for (int i = 0; i < 3; i++) begin
            bit rdy, oob;
            int a;
            rdy = m_ready(i);
            oob = int'(addr) >= cfg_depth[i];
            if (rdy && re) begin
                m_rd_q[i]     = oob ? 8'h00 : m_mem[i][addr];
                m_rd_known[i] = oob || m_known[i][addr];
            end
            m_rv_q[i]   = rdy && re;
            m_err_q[i]  = rdy && (re || we) && oob;
            m_done_q[i] = 1'b0;
            if (m_clear_left[i] > 0) begin
                a = cfg_depth[i] - m_clear_left[i];
                m_mem[i][a] = 8'h00;
                m_known[i][a] = 1'b1;
                m_clear_left[i]--;
            end else if (m_loading[i]) begin
                if (load_valid) begin
                    a = (cfg_base[i] + m_load_cnt[i]) % cfg_depth[i];
                    m_mem[i][a] = load_data;
                    m_known[i][a] = 1'b1;
                    m_load_cnt[i]++;
                    if (load_last) begin
                        m_loading[i] = 1'b0;
                        m_done_q[i]  = 1'b1;
                    end
                end
            end else begin
                if (we && !oob) begin
                    m_mem[i][addr] = wdata;
                    m_known[i][addr] = 1'b1;
                end
                if (load_start) begin
                    m_loading[i]  = 1'b1;
                    m_load_cnt[i] = 0;
                end
            end
        end
    endtask

    task automatic model_compare();
        for (int i = 0; i < 3; i++) begin
            bit rdy, oob, ev, ee, kn;
            logic [7:0] ed;
            rdy = m_ready(i);
            oob = int'(addr) >= cfg_depth[i];
            if (cfg_lat[i] == 0) begin
                ev = rdy && re;
                ee = rdy && (re || we) && oob;
                if (ev) begin
                    ed = oob ? 8'h00 : m_mem[i][addr];
                    kn = oob || m_known[i][addr];
                end else begin
                    ed = m_rd_q[i];
                    kn = m_rd_known[i];
                end
            end else begin
                ev = m_rv_q[i];
                ee = m_err_q[i];
                ed = m_rd_q[i];
                kn = m_rd_known[i];
            end
            check("model_ready", i, 32'(ready_w[i]), 32'(rdy));
            check("model_rvalid", i, 32'(rvalid_w[i]), 32'(ev));
            check("model_addr_err", i, 32'(err_w[i]), 32'(ee));
            check("model_load_done", i, 32'(done_w[i]), 32'(m_done_q[i]));
            if (kn) check("model_rdata", i, 32'(rdata_w[i]), 32'(ed));
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic do_cycle(input bit r, input bit w, input logic [7:0] a, input logic [7:0] wd,
                            input bit ls, input bit lv, input bit ll, input logic [7:0] ld);
        re = r; we = w; addr = a; wdata = wd;
        load_start = ls; load_valid = lv; load_last = ll; load_data = ld;
        #1;
        model_compare();
        for (int i = 0; i < 3; i++) begin
            obs_rdata[i]  = rdata_w[i];
            obs_rvalid[i] = rvalid_w[i];
            obs_ready[i]  = ready_w[i];
            obs_err[i]    = err_w[i];
            obs_done[i]   = done_w[i];
        end
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic idle();
        do_cycle(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        idle();
        check("reset_ready_a", 0, 32'(obs_ready[0]), 32'd0);
        check("reset_ready_c", 2, 32'(obs_ready[2]), 32'd1);
        check("reset_rdata_a", 0, 32'(obs_rdata[0]), 32'd0);
        idle();
        reset = 1'b0;
    endtask

    task automatic wait_ready(input int idx, output int n);
        bit got;
        got = 1'b0;
        n = 0;
        for (int k = 0; k < 400; k++) begin
            idle();
            if (obs_ready[idx]) begin
                got = 1'b1;
                break;
            end
            n++;
        end
        check("ready_timeout", idx, 32'(got), 32'd1);
    endtask

    typedef struct {
        int         dut;
        bit         re;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         chk;
        bit         exp_rv;
        bit         chk_rd;
        logic [7:0] exp_rd;
        bit         exp_err;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int n, pulses;
        vecs[0]  = '{0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0};
        vecs[1]  = '{0, 1, 0, 8'h7F, 8'h00, 1, 1, 1, 8'h00, 0};
        vecs[2]  = '{0, 1, 0, 8'hFF, 8'h00, 1, 1, 1, 8'h00, 0};
        vecs[3]  = '{0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h00, 0};
        vecs[4]  = '{0, 0, 1, 8'h10, 8'hA5, 1, 0, 1, 8'h00, 0};
        vecs[5]  = '{0, 1, 0, 8'h10, 8'h00, 1, 0, 1, 8'h00, 0};
        vecs[6]  = '{0, 1, 1, 8'h10, 8'h3C, 1, 1, 1, 8'hA5, 0};
        vecs[7]  = '{0, 1, 0, 8'h10, 8'h00, 1, 1, 1, 8'hA5, 0};
        vecs[8]  = '{0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h3C, 0};
        vecs[9]  = '{1, 0, 1, 8'hC8, 8'h55, 1, 0, 0, 8'h00, 0};
        vecs[10] = '{1, 1, 0, 8'hC8, 8'h00, 1, 0, 0, 8'h00, 1};
        vecs[11] = '{1, 1, 0, 8'hC7, 8'h00, 1, 1, 1, 8'h00, 1};
        vecs[12] = '{1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h00, 0};
        vecs[13] = '{2, 0, 1, 8'h05, 8'h9E, 1, 0, 0, 8'h00, 0};
        vecs[14] = '{2, 1, 0, 8'h05, 8'h00, 1, 1, 1, 8'h9E, 0};
        vecs[15] = '{2, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h9E, 0};

        re = 0; we = 0; addr = 0; wdata = 0;
        load_start = 0; load_valid = 0; load_last = 0; load_data = 0;
        @(negedge clock);

        // Boot clear takes exactly DEPTH cycles after reset release
        apply_reset();
        wait_ready(0, n);
        check("clear_cycles", 0, 32'(n), 32'd256);

        foreach (vecs[k]) begin
            do_cycle(vecs[k].re, vecs[k].we, vecs[k].addr, vecs[k].wdata, 0, 0, 0, 8'h00);
            if (vecs[k].chk) begin
                check("vec_rvalid", vecs[k].dut, 32'(obs_rvalid[vecs[k].dut]), 32'(vecs[k].exp_rv));
                check("vec_addr_err", vecs[k].dut, 32'(obs_err[vecs[k].dut]), 32'(vecs[k].exp_err));
                if (vecs[k].chk_rd)
                    check("vec_rdata", vecs[k].dut, 32'(obs_rdata[vecs[k].dut]), 32'(vecs[k].exp_rd));
            end
        end

        // Load burst with stalls wrapping across the top of the array
        pulses = 0;
        do_cycle(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00);
        do_cycle(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h11);
        check("load_ready_low", 0, 32'(obs_ready[0]), 32'd0);
        do_cycle(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        check("load_ready_low", 0, 32'(obs_ready[0]), 32'd0);
        do_cycle(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h22);
        check("load_ready_low", 0, 32'(obs_ready[0]), 32'd0);
        do_cycle(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        do_cycle(0, 0, 8'h00, 8'h00, 0, 1, 1, 8'h33);
        check("load_ready_low", 0, 32'(obs_ready[0]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            idle();
            if (obs_done[0]) pulses++;
        end
        check("load_done_pulses", 0, 32'(pulses), 32'd1);
        do_cycle(1, 0, 8'hFE, 8'h00, 0, 0, 0, 8'h00);
        do_cycle(1, 0, 8'hFF, 8'h00, 0, 0, 0, 8'h00);
        check("load_mem_fe", 0, 32'(obs_rdata[0]), 32'h11);
        do_cycle(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        check("load_mem_ff", 0, 32'(obs_rdata[0]), 32'h22);
        idle();
        check("load_mem_00", 0, 32'(obs_rdata[0]), 32'h33);

        // Reset after two of four load words; CPU write while not ready is dropped
        pulses = 0;
        do_cycle(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00);
        do_cycle(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h44);
        do_cycle(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h55);
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            idle();
            if (obs_done[0]) pulses++;
        end
        do_cycle(0, 1, 8'h03, 8'h77, 0, 0, 0, 8'h00);
        check("t6_ready_low", 0, 32'(obs_ready[0]), 32'd0);
        wait_ready(0, n);
        check("t6_clear_cycles", 0, 32'(n + 11), 32'd256);
        for (int k = 0; k < 3; k++) begin
            idle();
            if (obs_done[0]) pulses++;
        end
        check("t6_no_load_done", 0, 32'(pulses), 32'd0);
        do_cycle(1, 0, 8'h03, 8'h00, 0, 0, 0, 8'h00);
        idle();
        check("t6_dropped_write", 0, 32'(obs_rdata[0]), 32'h00);

        // Randomised traffic, loads included, checked against the model every cycle
        for (int k = 0; k < 1500; k++) begin
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)), 8'($urandom),
                     ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 5) == 0), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
